// File: rtl/inv_factorial_pkg.sv
// Shared types and constants for the inverse-factorial engine.
// Imported by the datapath and the top-level FSM.
package inv_factorial_pkg;

  localparam int TW_DEF = 8;
  localparam int PW_DEF = 12;
  localparam int N_MAX  = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MUL   = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/inv_factorial_datapath.sv
// Repeated-addition datapath: holds k!, forms (k+1)! by adding
// k! to itself m times, and compares against the latched target.
module inv_factorial_datapath
  import inv_factorial_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          prep,
  input  logic          add,
  input  logic          advance,
  input  logic [TW-1:0] target,
  output logic [3:0]    k_o,
  output logic          cnt_last,
  output logic          gt,
  output logic          eq
);

  logic [TW-1:0] t_q, t_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [3:0]    k_q, k_d;
  logic [3:0]    m_q, m_d;
  logic [3:0]    cnt_q, cnt_d;

  // Next-state of every datapath register from the FSM controls.
  always_comb begin
    t_d    = t_q;
    acc_d  = acc_q;
    prod_d = prod_q;
    k_d    = k_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    if (load) begin
      t_d   = target;
      acc_d = {{(PW-1){1'b0}}, 1'b1};
      k_d   = 4'd1;
    end
    if (prep) begin
      prod_d = '0;
      cnt_d  = k_q + 4'd1;
      m_d    = k_q + 4'd1;
    end
    if (add) begin
      prod_d = prod_q + acc_q;
      cnt_d  = cnt_q - 4'd1;
    end
    if (advance) begin
      acc_d = prod_q;
      k_d   = m_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      k_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
    end else begin
      t_q    <= t_d;
      acc_q  <= acc_d;
      prod_q <= prod_d;
      k_q    <= k_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
    end
  end

  assign k_o      = k_q;
  assign cnt_last = (cnt_q == 4'd1);
  assign gt       = prod_q > {{(PW-TW){1'b0}}, t_q};
  assign eq       = (acc_q[TW-1:0] == t_q) &&
                    (acc_q[PW-1:TW] == '0);

endmodule

// File: rtl/inv_factorial_top.sv
// Inverse-factorial engine: largest n with n! <= target,
// plus exact-match and zero-target error flags.
module inv_factorial_top
  import inv_factorial_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [TW-1:0] target,
  output logic [3:0]    n_out,
  output logic          exact,
  output logic          err,
  output logic          busy,
  output logic          done
);

  state_e state_q, state_d;
  logic [3:0] n_q, n_d;
  logic exact_q, exact_d;
  logic err_q, err_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic load, prep, add, advance;
  logic [3:0] k;
  logic cnt_last, gt, eq;

  inv_factorial_datapath #(
    .TW(TW),
    .PW(PW)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .prep    (prep),
    .add     (add),
    .advance (advance),
    .target  (target),
    .k_o     (k),
    .cnt_last(cnt_last),
    .gt      (gt),
    .eq      (eq)
  );

  // Control sequencing and next values of the result registers.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    exact_d = exact_q;
    err_d   = err_q;
    load    = 1'b0;
    prep    = 1'b0;
    add     = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (target != '0) begin
            load    = 1'b1;
            state_d = CHECK;
          end else begin
            n_d     = 4'd0;
            exact_d = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      CHECK: begin
        prep    = 1'b1;
        state_d = MUL;
      end
      MUL: begin
        add = 1'b1;
        if (cnt_last) state_d = CMP;
      end
      CMP: begin
        if (gt) begin
          n_d     = k;
          exact_d = eq;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          advance = 1'b1;
          state_d = CHECK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      exact_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      exact_q <= exact_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign n_out = n_q;
  assign exact = exact_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_inv_factorial_top.sv
// Directed bench for inv_factorial_top: results, latency,
// busy/done framing, ignored restart and mid-run reset.
module tb_inv_factorial_top;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] target;
  logic [3:0] n_out;
  logic       exact, err, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inv_factorial_top dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .target(target),
    .n_out (n_out),
    .exact (exact),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run(input logic [7:0] tgt, input int en,
                     input int ex, input int er, input int el,
                     input int rep);
    int lat;
    int busy_bad;
    string s;
    s = $sformatf("t%0d", tgt);
    start  = 1'b1;
    target = tgt;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_bad = 0;
    while (!done && lat < 60) begin
      if (!busy) busy_bad++;
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (rep != 0 && lat == rep) begin
        start  = 1'b1;
        target = 8'd6;
      end
    end
    start = 1'b0;
    check({s, "_latency"}, lat, el);
    check({s, "_n_out"}, int'(n_out), en);
    check({s, "_exact"}, int'(exact), ex);
    check({s, "_err"}, int'(err), er);
    check({s, "_busy_at_done"}, int'(busy), 1);
    check({s, "_busy_gaps"}, busy_bad, 0);
    @(posedge clk); #1;
    check({s, "_done_pulse_1cyc"}, int'(done), 0);
    check({s, "_idle_after"}, int'(busy), 0);
  endtask

  int lat_tab [1:5] = '{4, 9, 15, 22, 30};

  initial begin
    int dn;
    int f;
    reset  = 1'b1;
    start  = 1'b0;
    target = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_n_out", int'(n_out), 0);
    check("rst_exact", int'(exact), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run(8'd120, 5, 1, 0, 30, 0);
    run(8'd100, 4, 0, 0, 22, 0);
    run(8'd255, 5, 0, 0, 30, 0);
    run(8'd1,   1, 1, 0, 4,  0);
    run(8'd2,   2, 1, 0, 9,  0);
    run(8'd0,   0, 0, 1, 0,  0);
    run(8'd24,  4, 1, 0, 22, 10);

    // New run aborted by reset five edges in.
    start  = 1'b1;
    target = 8'd120;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    check("abort_n_out_held", int'(n_out), 4);
    check("abort_exact_held", int'(exact), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_n_out", int'(n_out), 0);
    check("abort_exact", int'(exact), 0);
    check("abort_err", int'(err), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    check("abort_no_done", dn, 0);

    // Round trip: n -> n! -> n.
    for (int n = 1; n <= 5; n++) begin
      f = 1;
      for (int i = 2; i <= n; i++) f = f * i;
      run(f[7:0], n, 1, 0, lat_tab[n], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
